// File: rtl/pe2_writeback.sv
// pe2_writeback
//   Downstream companion of the PE2 butterfly. Each operand pair's RAM addresses
//   travel through a tag delay line matched to the PE2 latency, so when the
//   butterfly result appears it is re-joined with the addresses it belongs to.
//   Aligned results are queued in a small FIFO that feeds the coefficient-RAM
//   write port through a valid/ready handshake. PE2 cannot stall, so the FIFO
//   absorbs write-port backpressure; a result arriving at a full FIFO with no
//   pop is dropped and flagged. Completed handshakes are counted per NTT stage.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   stage_start         one-cycle pulse that opens a stage (honoured in IDLE only)
//   in_valid            u/v presented to PE2 this cycle (accepted in ACTIVE only)
//   in_addr_u/v         RAM addresses of the u and v operands
//   bf_lower/bf_upper   PE2 sum / difference outputs
//   wr_valid/wr_ready   write-port handshake; wr_valid = FIFO not empty
//   wr_addr_sum/diff    head addresses (u address for sum, v address for diff)
//   wr_data_sum/diff    head data (bf_lower sample, bf_upper sample)
//   fifo_level          current FIFO occupancy
//   stage_done          one-cycle pulse after the last pair of a stage is written
//   overflow            sticky drop indicator, cleared only by reset
module pe2_writeback #(
  parameter int data_width  = 12,
  parameter int addr_width  = 7,
  parameter int PE_LAT      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int BLOCK_PAIRS = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stage_start,
  input  logic                          in_valid,
  input  logic [addr_width-1:0]         in_addr_u,
  input  logic [addr_width-1:0]         in_addr_v,
  input  logic [data_width-1:0]         bf_lower,
  input  logic [data_width-1:0]         bf_upper,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [addr_width-1:0]         wr_addr_sum,
  output logic [data_width-1:0]         wr_data_sum,
  output logic [addr_width-1:0]         wr_addr_diff,
  output logic [data_width-1:0]         wr_data_diff,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          stage_done,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BLOCK_PAIRS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic                  vld;
    logic [addr_width-1:0] u;
    logic [addr_width-1:0] v;
  } tag_t;

  typedef struct packed {
    logic [addr_width-1:0] u;
    logic [addr_width-1:0] v;
    logic [data_width-1:0] lo;
    logic [data_width-1:0] up;
  } entry_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        pair_cnt_q, pair_cnt_d;
  tag_t [PE_LAT-1:0]       tag_q, tag_d;
  entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  entry_t                  head_q, head_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    do_push_s;
  entry_t                  new_entry_s;

  // Tag delay line: a tag entered on one edge sits at the last stage exactly
  // when PE2 presents the matching result.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = {in_valid && (state_q == ACTIVE), in_addr_u, in_addr_v};
    for (int i = 1; i < PE_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Result FIFO: push from the tag pipe output, pop on write-port handshake.
  always_comb begin
    push_s      = tag_q[PE_LAT-1].vld;
    new_entry_s = {tag_q[PE_LAT-1].u, tag_q[PE_LAT-1].v, bf_lower, bf_upper};
    full_s      = (count_q == LVL_W'(FIFO_DEPTH));
    pop_s       = (count_q != {LVL_W{1'b0}}) && wr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push_s   = push_s && (!full_s || pop_s);
    mem_d       = mem_q;

    if (do_push_s) begin
      mem_d[wr_ptr_q] = new_entry_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    // Head register: holds the last head while empty; otherwise the entry at
    // the new read pointer, which is the incoming one if it lands there now.
    if (count_d == {LVL_W{1'b0}}) begin
      head_d = head_q;
    end else if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = new_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Stage FSM and pair counter; only handshakes while ACTIVE are counted.
  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    case (state_q)
      IDLE: begin
        if (stage_start) begin
          state_d    = ACTIVE;
          pair_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d    = IDLE;
        end
      end
      ACTIVE: begin
        if (pop_s && (pair_cnt_q == CNT_W'(BLOCK_PAIRS - 1))) begin
          state_d    = DONE;
          pair_cnt_d = {CNT_W{1'b0}};
        end else if (pop_s) begin
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end else begin
          pair_cnt_d = pair_cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        pair_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pair_cnt_q <= {CNT_W{1'b0}};
      tag_q      <= '0;
      mem_q      <= '0;
      head_q     <= '0;
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {LVL_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      tag_q      <= tag_d;
      mem_q      <= mem_d;
      head_q     <= head_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_valid     = (count_q != {LVL_W{1'b0}});
  assign fifo_level   = count_q;
  assign overflow     = ovf_q;
  assign stage_done   = (state_q == DONE);
  assign wr_addr_sum  = head_q.u;
  assign wr_data_sum  = head_q.lo;
  assign wr_addr_diff = head_q.v;
  assign wr_data_diff = head_q.up;

endmodule

// File: tb/tb_pe2_writeback.sv
module tb_pe2_writeback;
  localparam int DW    = 12;
  localparam int AW    = 7;
  localparam int PE_LAT = 4;
  localparam int DEPTH = 4;
  localparam int BP    = 128;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 3 + LW + 2 * AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          stage_start, in_valid, wr_ready;
  logic [AW-1:0] in_addr_u, in_addr_v;
  logic [DW-1:0] bf_lower, bf_upper;
  logic          wr_valid, stage_done, overflow;
  logic [AW-1:0] wr_addr_sum, wr_addr_diff;
  logic [DW-1:0] wr_data_sum, wr_data_diff;
  logic [LW-1:0] fifo_level;

  pe2_writeback #(.data_width(DW), .addr_width(AW), .PE_LAT(PE_LAT),
                  .FIFO_DEPTH(DEPTH), .BLOCK_PAIRS(BP)) dut (
    .clk(clk), .rst(rst), .stage_start(stage_start), .in_valid(in_valid),
    .in_addr_u(in_addr_u), .in_addr_v(in_addr_v),
    .bf_lower(bf_lower), .bf_upper(bf_upper),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr_sum(wr_addr_sum), .wr_data_sum(wr_data_sum),
    .wr_addr_diff(wr_addr_diff), .wr_data_diff(wr_data_diff),
    .fifo_level(fifo_level), .stage_done(stage_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: PE2 environment pipe (what was presented PE_LAT cycles
  // ago and whether the writeback accepted it), result queue, stage status.
  typedef struct packed {
    logic          acc;
    logic [AW-1:0] u;
    logic [AW-1:0] v;
    logic [DW-1:0] lo;
    logic [DW-1:0] up;
  } pend_t;

  pend_t pipe[$];
  pend_t mq[$];
  pend_t last_head;
  logic  m_ovf, m_done, m_active;
  int    m_cnt;
  int    checks, failures, cyc;

  function automatic logic [VW-1:0] exp_vec();
    pend_t h;
    logic  v;
    v = (mq.size() > 0);
    if (v) h = mq[0];
    else   h = last_head;
    return {v, LW'(mq.size()), m_ovf, m_done, h.u, h.lo, h.v, h.up};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {wr_valid, fifo_level, overflow, stage_done,
            wr_addr_sum, wr_data_sum, wr_addr_diff, wr_data_diff};
  endfunction

  function automatic int inflight();
    int c = 0;
    foreach (pipe[i]) if (pipe[i].acc) c++;
    return c;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0; m_done = 1'b0; m_active = 1'b0; m_cnt = 0;
    last_head = '0;
    foreach (pipe[i]) pipe[i].acc = 1'b0;
  endtask

  // One clock cycle: called at a negedge, drives inputs, advances the model.
  task automatic do_cycle(input logic ss, input logic iv, input logic [AW-1:0] au,
                          input logic [AW-1:0] av, input logic rdy,
                          input logic [DW-1:0] lo, input logic [DW-1:0] up);
    pend_t front, ent;
    logic  pop, act_before;
    front = pipe[0];
    act_before = m_active;
    stage_start = ss; in_valid = iv; in_addr_u = au; in_addr_v = av; wr_ready = rdy;
    bf_lower = front.lo; bf_upper = front.up;
    @(posedge clk);
    pop = (mq.size() > 0) && rdy;
    if (pop) last_head = mq.pop_front();
    if (front.acc) begin
      if (mq.size() < DEPTH) mq.push_back(front);
      else m_ovf = 1'b1;
    end
    if (m_done) m_done = 1'b0;
    else if (m_active) begin
      if (pop) begin
        m_cnt++;
        if (m_cnt == BP) begin m_active = 1'b0; m_done = 1'b1; m_cnt = 0; end
      end
    end else if (ss) begin
      m_active = 1'b1; m_cnt = 0;
    end
    ent = {iv && act_before, au, av, lo, up};
    void'(pipe.pop_front());
    pipe.push_back(ent);
    @(negedge clk);
    cyc++;
  endtask

  task automatic assert_reset();
    stage_start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    #2 rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    checks++;
    if ({wr_valid, fifo_level, overflow, stage_done} !== '0) begin
      failures++;
      $display("FAIL reset_por got=%b required=0", {wr_valid, fifo_level, overflow, stage_done});
    end
    rst = 1'b1;
    do_cycle(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 12'd0, 12'd0);
    for (int i = 0; i < 5; i++)
      do_cycle(1'b0, 1'b1, AW'($urandom), AW'($urandom), 1'b0, DW'($urandom), DW'($urandom));
    n = 0;
    while (mq.size() < 3 && n < 20) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, DW'($urandom), DW'($urandom));
      n++;
    end
    checks++;
    if (fifo_level !== 3'd3) begin
      failures++;
      $display("FAIL reset_prefill_level got=%0d required=3", fifo_level);
    end
    assert_reset();
    checks++;
    if (obs_vec() !== {VW{1'b0}}) begin
      failures++;
      $display("FAIL reset_async got=%h required=0", obs_vec());
    end
    release_reset();
    for (int i = 0; i < PE_LAT + 3; i++) begin
      checks++;
      if (wr_valid !== 1'b0 || fifo_level !== 3'd0 || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_no_push cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_latency();
    do_cycle(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 12'd0, 12'd0);
    do_cycle(1'b0, 1'b1, 7'd3, 7'd67, 1'b0, 12'h123, 12'h456);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL latency_model k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k < 5) begin
        checks++;
        if (wr_valid !== 1'b0) begin
          failures++;
          $display("FAIL latency_early k=%0d wr_valid got=%b required=0", k, wr_valid);
        end
        do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, DW'($urandom), DW'($urandom));
      end
    end
    checks++;
    if ({wr_valid, wr_addr_sum, wr_data_sum, wr_addr_diff, wr_data_diff} !==
        {1'b1, 7'd3, 12'h123, 7'd67, 12'h456}) begin
      failures++;
      $display("FAIL latency_align got=%b/%0d/%h/%0d/%h required=1/3/123/67/456",
               wr_valid, wr_addr_sum, wr_data_sum, wr_addr_diff, wr_data_diff);
    end
    do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, DW'($urandom), DW'($urandom));
    checks++;
    if (wr_valid !== 1'b0 || wr_data_sum !== 12'h123 || wr_addr_diff !== 7'd67) begin
      failures++;
      $display("FAIL latency_hold got=%b/%h/%0d required=0/123/67", wr_valid, wr_data_sum, wr_addr_diff);
    end
  endtask

  task automatic test_backpressure();
    pend_t gen[5];
    int n;
    assert_reset(); release_reset();
    do_cycle(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 12'd0, 12'd0);
    for (int i = 0; i < 5; i++) begin
      gen[i] = {1'b1, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom)};
      do_cycle(1'b0, 1'b1, gen[i].u, gen[i].v, 1'b0, gen[i].lo, gen[i].up);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL bp_full got=%0d/%b required=4/0", fifo_level, overflow);
        end
      end
      do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, DW'($urandom), DW'($urandom));
    end
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_overflow got=%0d/%b required=4/1", fifo_level, overflow);
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bp_drain_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (wr_valid === 1'b1) begin
        checks++;
        if (n > 3 || {wr_addr_sum, wr_addr_diff, wr_data_sum, wr_data_diff} !==
            {gen[n].u, gen[n].v, gen[n].lo, gen[n].up}) begin
          failures++;
          $display("FAIL bp_drain_order n=%0d got=%0d/%0d/%h/%h", n, wr_addr_sum, wr_addr_diff,
                   wr_data_sum, wr_data_diff);
        end
        n++;
      end
      do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, DW'($urandom), DW'($urandom));
    end
    checks++;
    if (n !== 4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_count got=%0d/%b required=4/1", n, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    pend_t gen[12];
    int n;
    logic rdy;
    assert_reset(); release_reset();
    do_cycle(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 12'd0, 12'd0);
    for (int i = 0; i < 12; i++)
      gen[i] = {1'b1, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom)};
    n = 0;
    for (int c = 0; c < 20; c++) begin
      rdy = (c >= 8);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL fpp_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (c >= 8 && c <= 16) begin
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL fpp_level c=%0d got=%0d/%b required=4/0", c, fifo_level, overflow);
        end
      end
      if (rdy && wr_valid === 1'b1) begin
        checks++;
        if (n > 11 || {wr_addr_sum, wr_addr_diff, wr_data_sum, wr_data_diff} !==
            {gen[n].u, gen[n].v, gen[n].lo, gen[n].up}) begin
          failures++;
          $display("FAIL fpp_order n=%0d got=%0d/%0d/%h/%h", n, wr_addr_sum, wr_addr_diff,
                   wr_data_sum, wr_data_diff);
        end
        n++;
      end
      if (c < 12) do_cycle(1'b0, 1'b1, gen[c].u, gen[c].v, rdy, gen[c].lo, gen[c].up);
      else        do_cycle(1'b0, 1'b0, 7'd0, 7'd0, rdy, DW'($urandom), DW'($urandom));
    end
    checks++;
    if (n !== 12) begin
      failures++;
      $display("FAIL fpp_count got=%0d required=12", n);
    end
  endtask

  task automatic run_stage(input string name, input logic noisy);
    int presented, hs, pulses, hs_cyc, done_cyc;
    logic iv, rdy, ss;
    assert_reset(); release_reset();
    do_cycle(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 12'd0, 12'd0);
    presented = 0; hs = 0; pulses = 0; hs_cyc = -10; done_cyc = -10;
    for (int n = 0; n < 4000; n++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s_model cyc=%0d got=%h exp=%h", name, cyc, obs_vec(), exp_vec());
      end
      if (stage_done === 1'b1) begin pulses++; done_cyc = cyc; end
      if (hs == BP && cyc > hs_cyc + 2) break;
      rdy = 1'($urandom_range(0, 1));
      iv  = (presented < BP) && ($urandom_range(0, 3) != 0) && (mq.size() + inflight() < DEPTH);
      ss  = noisy && (hs < BP) && ($urandom_range(0, 7) == 0);
      if (iv) presented++;
      if (mq.size() > 0 && rdy) begin
        hs++;
        if (hs == BP) hs_cyc = cyc;
      end
      do_cycle(ss, iv, AW'($urandom), AW'($urandom), rdy, DW'($urandom), DW'($urandom));
    end
    checks++;
    if (pulses !== 1 || done_cyc !== hs_cyc + 1) begin
      failures++;
      $display("FAIL %s_done pulses=%0d done_cyc=%0d required 1 pulse at %0d", name, pulses,
               done_cyc, hs_cyc + 1);
    end
    do_cycle(1'b0, 1'b1, AW'($urandom), AW'($urandom), 1'b1, DW'($urandom), DW'($urandom));
    for (int k = 0; k < PE_LAT + 2; k++) begin
      checks++;
      if (wr_valid !== 1'b0 || fifo_level !== 3'd0 || stage_done !== 1'b0) begin
        failures++;
        $display("FAIL %s_idle_ignore k=%0d got=%b/%0d/%b required=0/0/0", name, k, wr_valid,
                 fifo_level, stage_done);
      end
      do_cycle(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, DW'($urandom), DW'($urandom));
    end
  endtask

  task automatic test_stage_completion();
    run_stage("stage", 1'b0);
  endtask

  task automatic test_start_while_active();
    run_stage("restart", 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b0; stage_start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    in_addr_u = '0; in_addr_v = '0; bf_lower = '0; bf_upper = '0;
    for (int i = 0; i < PE_LAT; i++) pipe.push_back('0);
    model_clear();
    test_reset();
    test_latency();
    test_backpressure();
    test_full_push_pop();
    test_stage_completion();
    test_start_while_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
